// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit engine and the byte-level core above it:
// command encodings, bit-engine state encoding and the per-phase bus levels.
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
    localparam logic [1:0] I2C_CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH_A = 3'd1,
        ST_PH_B = 3'd2,
        ST_PH_C = 3'd3,
        ST_PH_D = 3'd4
    } bit_state_t;

    // SCL/SDA pair; scl is the MSB so it packs as {scl, sda}.
    typedef struct packed {
        logic scl;
        logic sda;
    } bus_drive_t;

    // Bus levels to present while in the given phase of a command.
    // scl_now is the SCL level at entry, needed because START keeps SCL
    // where it was during phase A (low for a repeated START, high otherwise).
    function automatic bus_drive_t phase_drive(input logic [1:0] cmd,
                                               input logic       wbit,
                                               input bit_state_t phase,
                                               input logic       scl_now);
        bus_drive_t d;
        d.scl = 1'b1;
        d.sda = 1'b1;
        case (cmd)
            I2C_CMD_START: begin
                case (phase)
                    ST_PH_A: begin d.scl = scl_now; d.sda = 1'b1; end
                    ST_PH_B: begin d.scl = 1'b1;    d.sda = 1'b1; end
                    ST_PH_C: begin d.scl = 1'b1;    d.sda = 1'b0; end
                    default: begin d.scl = 1'b0;    d.sda = 1'b0; end
                endcase
            end
            I2C_CMD_STOP: begin
                d.scl = (phase != ST_PH_A);
                d.sda = (phase == ST_PH_C) || (phase == ST_PH_D);
            end
            default: begin
                // WRITE drives the data bit; READ releases SDA for the slave.
                d.scl = (phase == ST_PH_B) || (phase == ST_PH_C);
                d.sda = (cmd == I2C_CMD_READ) ? 1'b1 : wbit;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-phase timer: a down-counter that reloads the divider latched at
// command accept and pulses tick in the final cycle of every phase.
module i2c_phase_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_reg;
    logic [DIV_WIDTH-1:0] reload_reg;

    // Latch the divider on accept; count down while a command is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= '0;
            reload_reg <= '0;
        end else if (load) begin
            count_reg  <= div;
            reload_reg <= div;
        end else if (run) begin
            if (count_reg == '0) begin
                count_reg <= reload_reg;
            end else begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign tick = run && (count_reg == '0);

endmodule

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master engine: executes one START/STOP/WRITE/READ primitive
// per handshake as four timed quarter-phases and reports one response each.
module i2c_bit_ctrl
    import i2c_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd,
    input  logic                 cmd_bit,
    output logic                 rsp_valid,
    output logic                 rsp_bit,
    output logic                 busy,
    input  logic                 sda_i,
    output logic                 sda_o,
    output logic                 scl_o
);

    bit_state_t state;
    logic [1:0] cmd_reg;
    logic       bit_reg;
    logic       sample_reg;
    logic       sda_meta;
    logic       sda_sync;
    logic       accept;
    logic       running;
    logic       tick;

    assign accept  = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign running = (state != ST_IDLE);

    // Two-flop synchronizer for the asynchronous SDA pad; idles released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
        end
    end

    i2c_phase_timer #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .run   (running),
        .div   (clk_div),
        .tick  (tick)
    );

    // Phase sequencer with registered bus and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_reg    <= I2C_CMD_START;
            bit_reg    <= 1'b1;
            sample_reg <= 1'b0;
            scl_o      <= 1'b1;
            sda_o      <= 1'b1;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_bit    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_reg        <= cmd;
                        bit_reg        <= cmd_bit;
                        cmd_ready      <= 1'b0;
                        state          <= ST_PH_A;
                        {scl_o, sda_o} <= phase_drive(cmd, cmd_bit, ST_PH_A, scl_o);
                    end
                end
                ST_PH_A: begin
                    if (tick) begin
                        state          <= ST_PH_B;
                        {scl_o, sda_o} <= phase_drive(cmd_reg, bit_reg, ST_PH_B, scl_o);
                    end
                end
                ST_PH_B: begin
                    if (tick) begin
                        state          <= ST_PH_C;
                        {scl_o, sda_o} <= phase_drive(cmd_reg, bit_reg, ST_PH_C, scl_o);
                    end
                end
                ST_PH_C: begin
                    if (tick) begin
                        // Sample SDA at the end of the SCL-high window.
                        sample_reg     <= sda_sync;
                        state          <= ST_PH_D;
                        {scl_o, sda_o} <= phase_drive(cmd_reg, bit_reg, ST_PH_D, scl_o);
                    end
                end
                ST_PH_D: begin
                    if (tick) begin
                        // Bus levels hold at their phase-D values while idle.
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_bit   <= cmd_reg[1] ? sample_reg : 1'b0;
                        if (cmd_reg == I2C_CMD_START) begin
                            busy <= 1'b1;
                        end else if (cmd_reg == I2C_CMD_STOP) begin
                            busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: a per-cycle behavioural model built
// from the phase waveform table, directed scenarios and a randomized run.
module tb_i2c_bit_ctrl;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] clk_div = 16'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd = 2'b00;
    logic        cmd_bit = 1'b0;
    logic        rsp_valid;
    logic        rsp_bit;
    logic        busy;
    logic        sda_i;
    logic        sda_o;
    logic        scl_o;

    logic slave_sda = 1'b1;
    logic slave_fixed = 1'b1;
    logic rand_slave = 1'b0;

    // Open-drain bus: either side may pull SDA low.
    assign sda_i = sda_o & slave_sda;

    i2c_bit_ctrl #(.DIV_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_div   (clk_div),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_bit   (cmd_bit),
        .rsp_valid (rsp_valid),
        .rsp_bit   (rsp_bit),
        .busy      (busy),
        .sda_i     (sda_i),
        .sda_o     (sda_o),
        .scl_o     (scl_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        slave_sda = rand_slave ? 1'($urandom_range(0, 1)) : slave_fixed;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waveform table per command (rows START, STOP, WRITE, READ) and phase
    // A..D. -1 in the SCL table = keep the level at accept; -1 in the SDA
    // table = the command's data bit.
    int scl_tab [4][4] = '{'{-1, 1, 1, 0}, '{0, 1, 1, 1}, '{0, 1, 1, 0}, '{0, 1, 1, 0}};
    int sda_tab [4][4] = '{'{1, 1, 0, 0}, '{0, 0, 1, 1}, '{-1, -1, -1, -1}, '{1, 1, 1, 1}};

    // Model state.
    logic       hist [0:65535];
    bit         m_have = 1'b0;
    int         m_acc, m_n, k, p, t;
    logic [1:0] m_cmd;
    logic       m_bit, m_scl0;
    logic       e_scl = 1'b1, e_sda = 1'b1, e_busy = 1'b0, e_rsp = 1'b0;
    logic       e_ready, e_rv;

    // Observation bookkeeping for directed checks.
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    int   fall_cnt = 0, rise_cnt = 0, hi_cnt = 0, lo_cnt = 0;
    int   last_fall = 0, last_scl_rise = 0, last_rsp = 0, last_acc = 0;
    logic rise_q [$];
    int   acc_q [$];

    // Per-cycle model step and compare, away from the active edge.
    always @(negedge clk) begin
        hist[cyc] = sda_i;
        e_ready = 1'b1;
        e_rv = 1'b0;
        if (reset) begin
            m_have = 1'b0;
            e_scl = 1'b1; e_sda = 1'b1; e_busy = 1'b0; e_rsp = 1'b0;
        end else if (m_have) begin
            k = cyc - m_acc;
            if (k >= 1 && k <= 4 * m_n) begin
                p = (k - 1) / m_n;
                t = scl_tab[m_cmd][p];
                e_scl = (t < 0) ? m_scl0 : (t != 0);
                t = sda_tab[m_cmd][p];
                e_sda = (t < 0) ? m_bit : (t != 0);
                e_ready = 1'b0;
            end else if (k == 4 * m_n + 1) begin
                e_rv = 1'b1;
                e_rsp = m_cmd[1] ? hist[m_acc + 3 * m_n - 2] : 1'b0;
                if (m_cmd == C_START) e_busy = 1'b1;
                if (m_cmd == C_STOP)  e_busy = 1'b0;
                m_have = 1'b0;
            end
        end
        check("scl_o", 32'(scl_o), 32'(e_scl));
        check("sda_o", 32'(sda_o), 32'(e_sda));
        check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_bit", 32'(rsp_bit), 32'(e_rsp));
        check("busy", 32'(busy), 32'(e_busy));

        if (prev_scl && scl_o && prev_sda && !sda_o) begin fall_cnt++; last_fall = cyc; end
        if (prev_scl && scl_o && !prev_sda && sda_o) rise_cnt++;
        if (!prev_scl && scl_o) begin rise_q.push_back(sda_o); last_scl_rise = cyc; end
        if (!cmd_ready && scl_o) hi_cnt++;
        if (!cmd_ready && !sda_o) lo_cnt++;
        if (rsp_valid) last_rsp = cyc;
        prev_scl = scl_o;
        prev_sda = sda_o;

        if (!reset && cmd_valid && e_ready) begin
            m_have = 1'b1;
            m_acc = cyc;
            m_n = int'(clk_div) + 1;
            m_cmd = cmd;
            m_bit = cmd_bit;
            m_scl0 = e_scl;
            last_acc = cyc;
            acc_q.push_back(cyc);
            $display("accept cyc=%0d cmd=%0d bit=%0d N=%0d", cyc, cmd, cmd_bit, m_n);
        end
    end

    // Present a command and hold cmd_valid until it is accepted.
    task automatic issue(input logic [1:0] c, input logic b, input int div);
        bit ok;
        ok = 1'b0;
        cmd = c;
        cmd_bit = b;
        clk_div = 16'(div);
        cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no cmd_ready expected accept");
        end
        @(posedge clk); #1;
    endtask

    // Drop cmd_valid and wait for the completion pulse.
    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid expected pulse");
        end
        $display("response cyc=%0d rsp_bit=%0d busy=%0d", cyc, rsp_bit, busy);
        @(posedge clk); #1;
    endtask

    int fc, rc, idx0;
    logic [7:0] pat;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a WRITE while the bus is owned.
        issue(C_START, 1'b0, 3);
        wait_rsp();
        check("busy_after_start", 32'(busy), 32'd1);
        issue(C_WRITE, 1'b0, 3);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_scl", 32'(scl_o), 32'd1);
        check("rst_sda", 32'(sda_o), 32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // START then STOP with N=5.
        fc = fall_cnt;
        issue(C_START, 1'b0, 4);
        wait_rsp();
        check("start_latency", 32'(last_rsp - last_acc), 32'd21);
        check("start_busy", 32'(busy), 32'd1);
        check("start_sda_fall_scl_hi", 32'(fall_cnt - fc), 32'd1);
        rc = rise_cnt;
        issue(C_STOP, 1'b0, 4);
        wait_rsp();
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_sda_rise_scl_hi", 32'(rise_cnt - rc), 32'd1);

        // WRITE 0 with a released slave.
        hi_cnt = 0; lo_cnt = 0;
        issue(C_WRITE, 1'b0, 4);
        wait_rsp();
        check("write_scl_hi_cycles", 32'(hi_cnt), 32'd10);
        check("write_sda_lo_cycles", 32'(lo_cnt), 32'd20);
        check("write_rsp_bit", 32'(rsp_bit), 32'd0);

        // READ with the slave pulling low in phase C, then released.
        lo_cnt = 0;
        issue(C_READ, 1'b0, 2);
        repeat (6) @(posedge clk);
        #1 slave_fixed = 1'b0;
        repeat (3) @(posedge clk);
        #1 slave_fixed = 1'b1;
        wait_rsp();
        check("read0_rsp_bit", 32'(rsp_bit), 32'd0);
        issue(C_READ, 1'b0, 2);
        wait_rsp();
        check("read1_rsp_bit", 32'(rsp_bit), 32'd1);
        check("read_sda_released", 32'(lo_cnt), 32'd0);

        // Back-to-back: START, 0xA5 MSB first, READ, STOP with N=3.
        pat = 8'hA5;
        idx0 = acc_q.size();
        issue(C_START, 1'b0, 2);
        for (int i = 0; i < 8; i++) begin
            issue(C_WRITE, pat[7 - i], 2);
            if (i == 0) rise_q.delete();
        end
        issue(C_READ, 1'b0, 2);
        issue(C_STOP, 1'b0, 2);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            if (acc_q.size() > idx0 + i + 1)
                check("b2b_period", 32'(acc_q[idx0 + i + 1] - acc_q[idx0 + i]), 32'd13);
            else
                check("b2b_accept_count", 32'(acc_q.size() - idx0), 32'd11);
        end
        for (int i = 0; i < 8; i++) begin
            if (rise_q.size() > i)
                check("b2b_sda_at_scl_hi", 32'(rise_q[i]), 32'(pat[7 - i]));
            else
                check("b2b_scl_rise_count", 32'(rise_q.size()), 32'd8);
        end

        // Repeated START while busy with clk_div changed mid-command.
        issue(C_START, 1'b0, 2);
        wait_rsp();
        issue(C_WRITE, 1'b1, 2);
        wait_rsp();
        fc = fall_cnt;
        issue(C_START, 1'b0, 2);
        cmd = C_WRITE;
        cmd_bit = 1'b1;
        repeat (2) @(posedge clk);
        #1 clk_div = 16'd7;
        idx0 = last_acc;
        issue(C_WRITE, 1'b1, 7);
        check("rstart_period", 32'(last_acc - idx0), 32'd13);
        check("rstart_scl_before_sda", 32'(last_fall - last_scl_rise), 32'd3);
        check("rstart_sda_fall", 32'(fall_cnt - fc), 32'd1);
        wait_rsp();
        check("rstart_next_latency", 32'(last_rsp - last_acc), 32'd33);
        check("rstart_busy", 32'(busy), 32'd1);
        issue(C_STOP, 1'b0, 2);
        wait_rsp();

        // Randomized commands, dividers, slave behaviour and gaps.
        rand_slave = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
            clk_div = 16'($urandom_range(0, 6));
            if (i == 39 || $urandom_range(0, 1) == 1) begin
                wait_rsp();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        rand_slave = 1'b0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bit_ctrl.md
# i2c_bit_ctrl

Bit-level I2C engine sitting directly downstream of the I2C byte/transaction FSM (`i2c_core`) in the Avalon I2C slave peripheral. It accepts one bus primitive at a time (START, STOP, WRITE bit, READ bit) over a valid/ready handshake. It generates the SCL waveform and the open-drain SDA waveform in four timed quarter-phases, samples SDA, and returns one response per command. Single-master bus only: SCL is push-pull, with no clock stretching and no arbitration.

## Interface
- DIV_WIDTH, 16: width of the phase divider input.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_div  in  DIV_WIDTH  quarter-phase length minus one, in clk cycles (N = clk_div+1); latched on command accept.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, able to accept.
- cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ.
- cmd_bit  in  1  SDA value for WRITE (0 = pull low); ignored otherwise.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_bit  out  1  SDA sampled in phase C (WRITE/READ); 0 for START/STOP.
- busy  out  1  bus owned: set on START completion, cleared on STOP completion.
- sda_i  in  1  SDA pad input (asynchronous).
- sda_o  out  1  SDA drive: 0 = pull low, 1 = release.
- scl_o  out  1  SCL, push-pull.

## Operation
- States: IDLE, PH_A, PH_B, PH_C, PH_D. Each PH_x lasts exactly N cycles.
- Accept in IDLE when cmd_valid & cmd_ready; latch cmd, cmd_bit, clk_div.
- Waveforms per phase (scl/sda):
  - START: A hold-current-scl/1, B 1/1, C 1/0, D 0/0. Covers both first START and repeated START.
  - STOP: A 0/0, B 1/0, C 1/1, D 1/1.
  - WRITE: A 0/b, B 1/b, C 1/b, D 0/b.
  - READ: same as WRITE with b = 1 (released).
- sda_i passes through a 2-flop synchronizer. rsp_bit captures the synchronized value in the last cycle of PH_C.
- After PH_D, return to IDLE. Outputs hold their PH_D values until the next command.
- All of the following are executed as normal and flag no error:
  - START while busy = 1: repeated start; busy stays 1.
  - STOP while busy = 0: busy stays 0.
  - WRITE/READ while busy = 0.
- cmd_valid while cmd_ready = 0 is ignored; the upstream FSM must hold it.
- clk_div changes mid-command have no effect until the next accept.
- clk_div = 0 is legal (N = 1). With N < 3, the 2-flop synchronizer delay means the phase-C sample lags the SCL rising edge; software must program clk_div >= 2 for valid reads.

## Timing
- Reset (async assert, sync deassert by the integrator) sets: scl_o=1, sda_o=1, cmd_ready=1, rsp_valid=0, rsp_bit=0, busy=0, state IDLE.
- Reset mid-command releases the bus immediately; the possibly spurious edge is accepted.
- All outputs are registered.
- Accept at cycle T:
  - cmd_ready=0 from T+1.
  - PH_A outputs are visible from T+1.
  - PH_D ends at T+4N.
  - At T+4N+1: rsp_valid=1, cmd_ready=1, and busy updates.
- A new command may be accepted in that same cycle. Command period is therefore 4N+1 cycles.
- rsp_bit is valid with rsp_valid and holds until the next completion.

## Structure
- Package i2c_pkg: the cmd encodings (I2C_CMD_START/STOP/WRITE/READ) and the state encoding. i2c_core imports the same package.
- One sub-module: i2c_phase_timer. It is a DIV_WIDTH down-counter, loaded with clk_div on accept and on every phase tick, and emits `tick` in the last cycle of each phase.
- The synchronizer and FSM stay in i2c_bit_ctrl.

## Test plan
- Reset values: assert reset mid-WRITE with clk_div=3 -> next cycle scl_o=1, sda_o=1, cmd_ready=1, busy=0.
- START then STOP with clk_div=4 (N=5):
  - START: SDA falls while SCL=1; rsp_valid at T+21; busy=1.
  - STOP: SDA rises while SCL=1; busy=0.
- WRITE cmd_bit=0 with a slave model holding SDA released -> sda_o=0 across all phases, SCL high for 10 cycles (B+C), rsp_bit=0.
- READ with the slave pulling sda_i=0 in phase C, clk_div=2 -> sda_o=1 throughout, rsp_bit=0. Repeat with sda_i=1 -> rsp_bit=1.
- Back-to-back: cmd_valid held high for START, then 8 WRITEs of 0xA5 (MSB first), READ, STOP -> each accept exactly 4N+1 cycles apart. SDA pattern during SCL high equals 1,0,1,0,0,1,0,1.
- Repeated START while busy, with clk_div changed mid-command from 2 to 7 -> SCL rises in PH_B before SDA falls; the current command keeps N=3; the next uses N=8; busy stays 1.
